// File: rtl/mandelbrot_pkg.sv
// Shared types and default frame geometry for the Mandelbrot pixel scheduler.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 640;
  localparam int DEF_HEIGHT    = 480;
  localparam int DEF_CR_OFFSET = -560;
  localparam int DEF_CI_OFFSET = -320;

  // Width of a counter that must be able to hold the value total itself.
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster coordinate stepper: walks cr along a line, wraps to the next ci at line end.
module mandelbrot_coord_gen #(
  parameter int BITWIDTH  = 10,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int CR_OFFSET = -560,
  parameter int CI_OFFSET = -320
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  output logic [BITWIDTH-1:0] cr,
  output logic [BITWIDTH-1:0] ci,
  output logic                last
);

  localparam logic [BITWIDTH-1:0] CR_FIRST = BITWIDTH'(CR_OFFSET);
  localparam logic [BITWIDTH-1:0] CR_LAST  = BITWIDTH'(CR_OFFSET + WIDTH - 1);
  localparam logic [BITWIDTH-1:0] CI_FIRST = BITWIDTH'(CI_OFFSET);
  localparam logic [BITWIDTH-1:0] CI_LAST  = BITWIDTH'(CI_OFFSET + HEIGHT - 1);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cr <= CR_FIRST;
      ci <= CI_FIRST;
    end else if (advance) begin
      if (cr == CR_LAST) begin
        cr <= CR_FIRST;
        ci <= ci + BITWIDTH'(1);
      end else begin
        cr <= cr + BITWIDTH'(1);
      end
    end
  end

  // High while the final pixel of the frame is the one on offer.
  assign last = (cr == CR_LAST) && (ci == CI_LAST);

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: raster-order job dispatch and in-order result collection over N workers.
module mandelbrot_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH    = 10,
  parameter int CTRWIDTH    = 7,
  parameter int NUM_WORKERS = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int CR_OFFSET   = DEF_CR_OFFSET,
  parameter int CI_OFFSET   = DEF_CI_OFFSET
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            frame_done,
  output logic [NUM_WORKERS-1:0]          job_valid,
  input  logic [NUM_WORKERS-1:0]          job_ready,
  output logic [BITWIDTH-1:0]             job_cr,
  output logic [BITWIDTH-1:0]             job_ci,
  input  logic [NUM_WORKERS-1:0]          res_valid,
  input  logic [NUM_WORKERS*CTRWIDTH-1:0] res_ctr,
  output logic [NUM_WORKERS-1:0]          res_ack,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [CTRWIDTH-1:0]             pix_ctr,
  output logic                            pix_last,
  output logic [1:0]                      state_dbg
);

  // Handshakes: a job moves when job_valid[w] && job_ready[w] at a clock edge;
  // a pixel moves when pix_valid && pix_ready, and res_ack mirrors that accept
  // combinationally so the owning worker frees its result on the same edge.

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNTW  = cnt_width(TOTAL);
  localparam int IDXW  = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(NUM_WORKERS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TOTAL - 1);

  state_t          state, state_nxt;
  logic [IDXW-1:0] disp_idx, coll_idx;
  logic [CNTW-1:0] dispatched, collected;
  logic            load, job_fire, pix_fire, coord_last;

  mandelbrot_coord_gen #(
    .BITWIDTH (BITWIDTH),
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CR_OFFSET(CR_OFFSET),
    .CI_OFFSET(CI_OFFSET)
  ) u_coord_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(job_fire),
    .cr     (job_cr),
    .ci     (job_ci),
    .last   (coord_last)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    job_valid = '0;
    job_fire  = 1'b0;
    res_ack   = '0;
    // Only the worker whose turn it is may present; others wait, keeping raster order.
    pix_valid = (state != ST_IDLE) && res_valid[coll_idx];
    pix_ctr   = res_ctr[coll_idx*CTRWIDTH +: CTRWIDTH];
    pix_last  = pix_valid && (collected == CNT_LAST);
    pix_fire  = pix_valid && pix_ready;
    if (pix_fire) res_ack[coll_idx] = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        job_valid[disp_idx] = 1'b1;
        job_fire            = job_ready[disp_idx];
        if (job_fire && coord_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pix_fire && pix_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      disp_idx   <= '0;
      coll_idx   <= '0;
      dispatched <= '0;
      collected  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == ST_DRAIN) && pix_fire && pix_last;
      if (load) begin
        disp_idx   <= '0;
        coll_idx   <= '0;
        dispatched <= '0;
        collected  <= '0;
      end else begin
        if (job_fire) begin
          disp_idx   <= (disp_idx == IDX_MAX) ? '0 : disp_idx + IDXW'(1);
          dispatched <= dispatched + CNTW'(1);
        end
        if (pix_fire) begin
          coll_idx  <= (coll_idx == IDX_MAX) ? '0 : coll_idx + IDXW'(1);
          collected <= collected + CNTW'(1);
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Scoreboard bench: 2-worker 4x2 frame plus a 1-worker 3x1 frame with behavioural workers.
module tb_mandelbrot_scheduler;

  localparam int BW = 10, CW = 7, NW = 2, W = 4, H = 2, WB = 3;
  localparam int CRO = -560, CIO = -320;
  localparam int TOT = W * H;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, start_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A (two workers)
  logic                   busy, frame_done, pix_valid, pix_ready, pix_last;
  logic [NW-1:0]          job_valid, job_ready, res_valid, res_ack;
  logic signed [BW-1:0]   job_cr, job_ci;
  logic [NW*CW-1:0]       res_ctr;
  logic [CW-1:0]          pix_ctr;
  logic [1:0]             state_dbg;

  mandelbrot_scheduler #(.BITWIDTH(BW), .CTRWIDTH(CW), .NUM_WORKERS(NW), .WIDTH(W),
    .HEIGHT(H), .CR_OFFSET(CRO), .CI_OFFSET(CIO)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .job_valid(job_valid), .job_ready(job_ready), .job_cr(job_cr), .job_ci(job_ci),
    .res_valid(res_valid), .res_ctr(res_ctr), .res_ack(res_ack), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_ctr(pix_ctr), .pix_last(pix_last), .state_dbg(state_dbg));

  // DUT B (single worker)
  logic                 busy_b, frame_done_b, pix_valid_b, pix_ready_b, pix_last_b;
  logic [0:0]           job_valid_b, job_ready_b, res_valid_b, res_ack_b;
  logic signed [BW-1:0] job_cr_b, job_ci_b;
  logic [CW-1:0]        res_ctr_b, pix_ctr_b;
  logic [1:0]           state_dbg_b;

  mandelbrot_scheduler #(.BITWIDTH(BW), .CTRWIDTH(CW), .NUM_WORKERS(1), .WIDTH(WB),
    .HEIGHT(1), .CR_OFFSET(CRO), .CI_OFFSET(CIO)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .frame_done(frame_done_b),
    .job_valid(job_valid_b), .job_ready(job_ready_b), .job_cr(job_cr_b), .job_ci(job_ci_b),
    .res_valid(res_valid_b), .res_ctr(res_ctr_b), .res_ack(res_ack_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready_b), .pix_ctr(pix_ctr_b), .pix_last(pix_last_b), .state_dbg(state_dbg_b));

  // scoreboard state
  int tests = 0, fails = 0;
  logic [CW:0]     exp_q[$];
  logic [2*BW-1:0] exp_jq[$];
  logic [CW:0]     exp_qb[$];
  int jobs_a = 0, pix_a = 0, jobs_exp_a = 0, pix_exp_a = 0, pix_b = 0, pix_exp_b = 0;
  int disp_w = 0, coll_w = 0, frame_base = 0;
  logic fd_due_a = 1'b0, fd_due_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // worker models: per-worker FIFO of (count, ready cycle); count = raster pixel index
  int   lat[NW], cap[NW];
  int   pv[NW][8], pt[NW][8], ph[NW], pc[NW];
  logic job_en;

  always @(posedge clk) begin
    logic [NW-1:0]    rv, jr;
    logic [NW*CW-1:0] rc;
    if (reset) begin
      for (int w = 0; w < NW; w++) begin ph[w] = 0; pc[w] = 0; end
      res_valid <= '0; job_ready <= '0; res_ctr <= '0;
    end else begin
      rv = '0; jr = '0; rc = '0;
      for (int w = 0; w < NW; w++) begin
        if (res_ack[w] && res_valid[w]) begin ph[w] = (ph[w] + 1) % 8; pc[w]--; end
        if (job_valid[w] && job_ready[w]) begin
          pv[w][(ph[w] + pc[w]) % 8] = (int'(job_ci) - CIO) * W + (int'(job_cr) - CRO);
          pt[w][(ph[w] + pc[w]) % 8] = cyc + lat[w];
          pc[w]++;
        end
        rv[w] = (pc[w] > 0) && (pt[w][ph[w]] <= cyc);
        rc[w*CW +: CW] = (pc[w] > 0) ? CW'(pv[w][ph[w]]) : '0;
        jr[w] = job_en && (pc[w] < cap[w]);
      end
      res_valid <= rv; res_ctr <= rc; job_ready <= jr;
    end
  end

  int   b_val, b_t;
  logic b_full;
  always @(posedge clk) begin
    if (reset) begin
      b_full = 1'b0;
      res_valid_b <= '0; job_ready_b <= '0; res_ctr_b <= '0;
    end else begin
      if (res_ack_b[0] && res_valid_b[0]) b_full = 1'b0;
      if (job_valid_b[0] && job_ready_b[0]) begin
        b_full = 1'b1;
        b_val  = (int'(job_ci_b) - CIO) * WB + (int'(job_cr_b) - CRO);
        b_t    = cyc + 2;
      end
      res_valid_b <= b_full && (b_t <= cyc);
      res_ctr_b   <= CW'(b_val);
      job_ready_b <= !b_full;
    end
  end

  // monitors
  always @(negedge clk) begin
    logic [CW:0]     ep;
    logic [2*BW-1:0] ej;
    if (!reset) begin
      if (frame_done || fd_due_a) begin
        check("frame_done_a", frame_done, fd_due_a);
        if (fd_due_a) check("busy_in_done_cycle_a", busy, 0);
        fd_due_a = 1'b0;
      end
      if (!pix_ready && res_ack != '0) check("ack_while_stalled", res_ack, 0);
      if ((job_valid & job_ready) != '0) begin
        jobs_a++;
        if (exp_jq.size() == 0) check("job_count_a", jobs_a, jobs_exp_a);
        else begin
          ej = exp_jq.pop_front();
          check("job_a", {job_valid, job_cr, job_ci}, {NW'(1 << disp_w), ej});
          disp_w = (disp_w + 1) % NW;
        end
      end
      if (pix_valid && pix_ready) begin
        pix_a++;
        if (exp_q.size() == 0) check("pixel_count_a", pix_a, pix_exp_a);
        else begin
          ep = exp_q.pop_front();
          check("pixel_a", {res_ack, pix_last, pix_ctr}, {NW'(1 << coll_w), ep});
          coll_w = (coll_w + 1) % NW;
          if (ep[CW]) fd_due_a = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [CW:0] ep;
    if (!reset) begin
      if (frame_done_b || fd_due_b) begin
        check("frame_done_b", frame_done_b, fd_due_b);
        fd_due_b = 1'b0;
      end
      if (pix_valid_b && pix_ready_b) begin
        pix_b++;
        if (exp_qb.size() == 0) check("pixel_count_b", pix_b, pix_exp_b);
        else begin
          ep = exp_qb.pop_front();
          check("pixel_b", {res_ack_b, pix_last_b, pix_ctr_b}, {1'b1, ep});
          if (ep[CW]) fd_due_b = 1'b1;
        end
      end
    end
  end

  // driver tasks (inputs change at posedge + 1)
  task automatic push_frame_a();
    for (int p = 0; p < TOT; p++) begin
      exp_jq.push_back({BW'(CRO + p % W), BW'(CIO + p / W)});
      exp_q.push_back({p == TOT - 1, CW'(p)});
      jobs_exp_a++; pix_exp_a++;
    end
  endtask

  task automatic start_a();
    @(posedge clk); #1;
    push_frame_a();
    frame_base = jobs_a;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || fd_due_a) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check(name, (exp_q.size() + exp_jq.size()) * 2 + int'(busy), 0);
  endtask

  task automatic wait_jobs_a(input int k);
    int n;
    n = 0;
    while (jobs_a - frame_base < k && n < 200) begin @(posedge clk); #1; n++; end
    check("jobs_reached", int'(jobs_a - frame_base >= k), 1);
  endtask

  initial begin
    int n, j0;
    reset = 1'b1; start = 1'b0; start_b = 1'b0; pix_ready = 1'b1; pix_ready_b = 1'b1;
    job_en = 1'b0; lat = '{3, 3}; cap = '{8, 8};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_job_valid", job_valid, 0);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_res_ack", res_ack, 0);
    check("reset_pix_last", pix_last, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_busy_b", busy_b, 0);
    job_en = 1'b1;

    // equal latency, pipelined workers
    start_a();
    wait_done_a("frame_equal_latency");

    // skewed latency, single-slot workers
    lat = '{1, 10}; cap = '{1, 1};
    start_a();
    wait_done_a("frame_skewed_latency");

    // downstream stall mid-frame
    lat = '{2, 2};
    start_a();
    wait_jobs_a(3);
    pix_ready = 1'b0; job_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 j0 = jobs_a;
    repeat (18) @(posedge clk);
    #1 check("stall_no_dispatch", jobs_a, j0);
    pix_ready = 1'b1; job_en = 1'b1;
    wait_done_a("frame_after_stall");

    // start during RUN ignored, start in frame_done cycle accepted
    lat = '{3, 3}; cap = '{8, 8};
    start_a();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!frame_done && n < 500) begin @(posedge clk); #1; n++; end
    check("frame_done_seen", frame_done, 1);
    push_frame_a();
    frame_base = jobs_a;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done_a("frame_back_to_back");

    // reset after three dispatches
    start_a();
    wait_jobs_a(3);
    reset = 1'b1;
    exp_q.delete(); exp_jq.delete();
    jobs_exp_a = jobs_a; pix_exp_a = pix_a;
    fd_due_a = 1'b0; disp_w = 0; coll_w = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_job_valid", job_valid, 0);
    check("midreset_pix_valid", pix_valid, 0);
    check("midreset_frame_done", frame_done, 0);
    start_a();
    wait_done_a("frame_after_reset");

    // single worker, 3x1 frame
    @(posedge clk); #1;
    for (int p = 0; p < WB; p++) begin
      exp_qb.push_back({p == WB - 1, CW'(p)});
      pix_exp_b++;
    end
    start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while ((exp_qb.size() != 0 || busy_b || fd_due_b) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("frame_single_worker", exp_qb.size() * 2 + int'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
